// File: rtl/row_transfer_pkg.sv
// Shared constants, state encoding and word-address composition for the row
// transfer engine and the DDR controller that serves it.
package row_transfer_pkg;

  localparam int WORDS       = 40;
  localparam int WORD_W      = 16;
  localparam int ROW_W       = WORDS * WORD_W;
  localparam int REFRESH_MID = 19;
  localparam int ROW_IDX_W   = 9;
  localparam int K_W         = 6;
  localparam int ADDR_W      = 24;
  localparam int SEL_W       = $clog2(ROW_W);

  localparam logic [K_W-1:0] LAST_K = K_W'(WORDS - 1);
  localparam logic [K_W-1:0] MID_K  = K_W'(REFRESH_MID);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } xfer_state_e;

  // Word address layout: zero-padded top, row index, then word-in-row.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ROW_IDX_W-1:0] row,
                                                  input logic [K_W-1:0]       k);
    return {{(ADDR_W - ROW_IDX_W - K_W){1'b0}}, row, k};
  endfunction

endpackage

// File: rtl/row_transfer_if.sv
// Request/response and DDR word-port signals of the row transfer engine.
// master = requester plus memory side (testbench), slave = the engine.
interface row_transfer_if;
  import row_transfer_pkg::*;

  logic                 start;
  logic                 doWrite;
  logic                 doRead;
  logic [ROW_IDX_W-1:0] writeRowIndex;
  logic [ROW_IDX_W-1:0] readRowIndex;
  logic [ROW_W-1:0]     writeRow;
  logic [ROW_W-1:0]     readRow;
  logic                 busy;
  logic                 done;
  logic                 write;
  logic [ADDR_W-1:0]    writeAddress;
  logic [WORD_W-1:0]    writeData;
  logic                 writeAcknowledge;
  logic                 read;
  logic [ADDR_W-1:0]    readAddress;
  logic [WORD_W-1:0]    readData;
  logic                 readAcknowledge;
  logic                 refresh;

  modport master (
    output start, doWrite, doRead, writeRowIndex, readRowIndex, writeRow,
    output writeAcknowledge, readData, readAcknowledge,
    input  readRow, busy, done, write, writeAddress, writeData,
    input  read, readAddress, refresh
  );

  modport slave (
    input  start, doWrite, doRead, writeRowIndex, readRowIndex, writeRow,
    input  writeAcknowledge, readData, readAcknowledge,
    output readRow, busy, done, write, writeAddress, writeData,
    output read, readAddress, refresh
  );

endinterface

// File: rtl/row_transfer.sv
// Row transfer engine: streams one 40-word row out to and/or in from the DDR
// word port, issuing refresh permits at phase entry, mid-row and row end.
module row_transfer
  import row_transfer_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  row_transfer_if.slave bus
);

  xfer_state_e          r_state, w_state_nxt;
  logic [K_W-1:0]       r_k, w_k_nxt, w_k_inc;
  logic [ROW_IDX_W-1:0] r_wr_row, w_wr_row_nxt;
  logic [ROW_IDX_W-1:0] r_rd_row, w_rd_row_nxt;
  logic                 r_rd_pend, w_rd_pend_nxt;
  logic [ROW_W-1:0]     r_snap, w_snap_nxt;
  logic [ROW_W-1:0]     r_read_row, w_read_row_nxt;
  logic                 r_write, w_write_nxt;
  logic                 r_read, w_read_nxt;
  logic                 r_refresh, w_refresh_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_busy, w_busy_nxt;
  logic [ADDR_W-1:0]    r_write_addr, w_write_addr_nxt;
  logic [ADDR_W-1:0]    r_read_addr, w_read_addr_nxt;
  logic [WORD_W-1:0]    r_write_data, w_write_data_nxt;
  logic [SEL_W-1:0]     w_cur_sel, w_inc_sel;
  logic                 w_last, w_mid;

  assign w_k_inc    = r_k + K_W'(1);
  assign w_cur_sel  = SEL_W'(r_k) * SEL_W'(WORD_W);
  assign w_inc_sel  = SEL_W'(w_k_inc) * SEL_W'(WORD_W);
  assign w_last     = (r_k == LAST_K);
  assign w_mid      = (r_k == MID_K);
  assign w_busy_nxt = (w_state_nxt != IDLE);

  // Next-state and next-output logic; every output is re-registered each cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_k_nxt          = r_k;
    w_wr_row_nxt     = r_wr_row;
    w_rd_row_nxt     = r_rd_row;
    w_rd_pend_nxt    = r_rd_pend;
    w_snap_nxt       = r_snap;
    w_read_row_nxt   = r_read_row;
    w_write_addr_nxt = r_write_addr;
    w_read_addr_nxt  = r_read_addr;
    w_write_data_nxt = r_write_data;
    w_write_nxt      = 1'b0;
    w_read_nxt       = 1'b0;
    w_refresh_nxt    = 1'b0;
    w_done_nxt       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_wr_row_nxt  = bus.writeRowIndex;
          w_rd_row_nxt  = bus.readRowIndex;
          w_rd_pend_nxt = bus.doRead;
          w_snap_nxt    = bus.writeRow;
          w_k_nxt       = K_W'(0);
          if (bus.doWrite) begin
            w_state_nxt      = WRITE;
            w_write_nxt      = 1'b1;
            w_write_addr_nxt = word_addr(bus.writeRowIndex, K_W'(0));
            w_write_data_nxt = bus.writeRow[WORD_W-1:0];
            w_refresh_nxt    = 1'b1;
          end else if (bus.doRead) begin
            w_state_nxt     = READ;
            w_read_nxt      = 1'b1;
            w_read_addr_nxt = word_addr(bus.readRowIndex, K_W'(0));
            w_refresh_nxt   = 1'b1;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WRITE: begin
        w_write_nxt = 1'b1;
        if (bus.writeAcknowledge) begin
          if (w_last) begin
            // Row-end refresh and read-entry refresh coincide into one pulse.
            w_write_nxt   = 1'b0;
            w_refresh_nxt = 1'b1;
            w_k_nxt       = K_W'(0);
            if (r_rd_pend) begin
              w_state_nxt     = READ;
              w_read_nxt      = 1'b1;
              w_read_addr_nxt = word_addr(r_rd_row, K_W'(0));
            end else begin
              w_state_nxt = IDLE;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_k_nxt          = w_k_inc;
            w_write_addr_nxt = word_addr(r_wr_row, w_k_inc);
            w_write_data_nxt = r_snap[w_inc_sel +: WORD_W];
            w_refresh_nxt    = w_mid;
          end
        end else begin
          w_state_nxt = WRITE;
        end
      end
      READ: begin
        w_read_nxt = 1'b1;
        if (bus.readAcknowledge) begin
          w_read_row_nxt[w_cur_sel +: WORD_W] = bus.readData;
          if (w_last) begin
            w_read_nxt    = 1'b0;
            w_refresh_nxt = 1'b1;
            w_k_nxt       = K_W'(0);
            w_state_nxt   = IDLE;
            w_done_nxt    = 1'b1;
          end else begin
            w_k_nxt         = w_k_inc;
            w_read_addr_nxt = word_addr(r_rd_row, w_k_inc);
            w_refresh_nxt   = w_mid;
          end
        end else begin
          w_state_nxt = READ;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_k          <= K_W'(0);
      r_wr_row     <= ROW_IDX_W'(0);
      r_rd_row     <= ROW_IDX_W'(0);
      r_rd_pend    <= 1'b0;
      r_snap       <= ROW_W'(0);
      r_read_row   <= ROW_W'(0);
      r_write      <= 1'b0;
      r_read       <= 1'b0;
      r_refresh    <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_write_addr <= ADDR_W'(0);
      r_read_addr  <= ADDR_W'(0);
      r_write_data <= WORD_W'(0);
    end else begin
      r_state      <= w_state_nxt;
      r_k          <= w_k_nxt;
      r_wr_row     <= w_wr_row_nxt;
      r_rd_row     <= w_rd_row_nxt;
      r_rd_pend    <= w_rd_pend_nxt;
      r_snap       <= w_snap_nxt;
      r_read_row   <= w_read_row_nxt;
      r_write      <= w_write_nxt;
      r_read       <= w_read_nxt;
      r_refresh    <= w_refresh_nxt;
      r_done       <= w_done_nxt;
      r_busy       <= w_busy_nxt;
      r_write_addr <= w_write_addr_nxt;
      r_read_addr  <= w_read_addr_nxt;
      r_write_data <= w_write_data_nxt;
    end
  end

  assign bus.readRow      = r_read_row;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.write        = r_write;
  assign bus.writeAddress = r_write_addr;
  assign bus.writeData    = r_write_data;
  assign bus.read         = r_read;
  assign bus.readAddress  = r_read_addr;
  assign bus.refresh      = r_refresh;

endmodule
